// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory responder: fill word, FSM states
// and the response record that travels down the read pipeline.
package imem_pkg;

  // addi x0,x0,0 -- used to pre-fill storage and to answer faulting fetches
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  // FILL walks the array writing NOPs; RUN serves fetches and loads
  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // One fetch response as it moves through the pipe
  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] pc;
    logic [31:0] data;
  } resp_t;

endpackage

// File: rtl/imem_read_pipe.sv
// LATENCY-deep chain of response records. The whole chain freezes while
// hold is high and clears asynchronously on rst.
module imem_read_pipe
  import imem_pkg::*;
#(
  parameter int          LATENCY  = 2,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  resp_t resp_next,
  output resp_t resp
);

  localparam resp_t CLEAR_RESP = '{valid: 1'b0, fault: 1'b0, pc: 32'd0, data: NOP_WORD};

  resp_t stage [LATENCY];

  // Shift one stage per unheld cycle; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= CLEAR_RESP;
    end else if (!hold) begin
      stage[0] <= resp_next;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign resp = stage[LATENCY-1];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the fetch stage. After reset the array
// is filled with NOPs, then fetches are served through a fixed-latency,
// stallable pipe and program words can be side-loaded.
//
// Handshake: there is no backpressure towards the PC register. A fetch is
// taken on a rising edge when ce && ready && !stall; otherwise it is simply
// dropped. instr_valid is a one-cycle strobe per accepted fetch, held only
// while stall is high; fault qualifies instr_valid.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           ce,
  input  logic [31:0]                    pc,
  input  logic                           stall,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
  output logic                           ready,
  output logic [31:0]                    instr,
  output logic [31:0]                    instr_pc,
  output logic                           instr_valid,
  output logic                           fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam resp_t CLEAR_RESP = '{valid: 1'b0, fault: 1'b0, pc: 32'd0, data: NOP_WORD};

  fsm_state_t       state;
  logic [AW-1:0]    fill_cnt;
  logic [31:0]      mem [DEPTH_WORDS];
  logic             accept;
  logic             fetch_fault;
  logic [AW-1:0]    word_idx;
  resp_t            fetch_resp;
  resp_t            capture_q;
  resp_t            pipe_out;

  assign accept      = ce && ready && !stall;
  assign word_idx    = pc[AW+1:2];
  assign fetch_fault = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);

  // Fill sequencer; ready follows the state one edge later
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= FILL;
      fill_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= (state == RUN);
      if (state == FILL) begin
        fill_cnt <= fill_cnt + AW'(1);
        if (fill_cnt == '1) state <= RUN;
      end
    end
  end

  // Storage writes: NOP fill in FILL, program loads only in RUN (stall-agnostic)
  always_ff @(posedge CLK) begin
    if (state == FILL) begin
      mem[fill_cnt] <= NOP_WORD;
    end else if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Response for the fetch on the inputs; faulting fetches never read the array
  always_comb begin
    fetch_resp.valid = accept;
    fetch_resp.fault = accept && fetch_fault;
    fetch_resp.pc    = pc;
    fetch_resp.data  = fetch_fault ? NOP_WORD : mem[word_idx];
  end

  // Capture at the accept edge samples the array before a same-edge load
  // lands, which gives read-first behaviour; the chain then adds LATENCY edges
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      capture_q <= CLEAR_RESP;
    end else if (!stall) begin
      capture_q <= fetch_resp;
    end
  end

  imem_read_pipe #(
    .LATENCY  (LATENCY),
    .NOP_WORD (NOP_WORD)
  ) u_read_pipe (
    .clk       (CLK),
    .rst       (RESET),
    .hold      (stall),
    .resp_next (capture_q),
    .resp      (pipe_out)
  );

  assign instr       = pipe_out.data;
  assign instr_pc    = pipe_out.pc;
  assign instr_valid = pipe_out.valid;
  assign fault       = pipe_out.fault;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed plus randomized bench for instr_mem_responder. The reference model
// is a plain word array plus a queue of expected responses, each due a fixed
// number of unstalled edges after its accept edge.
module tb_instr_mem_responder;

  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [31:0]   pc;
  logic          stall;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          fault;

  always #5 clk = ~clk;

  instr_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .NOP_WORD    (NOP)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .ce          (ce),
    .pc          (pc),
    .stall       (stall),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .ready       (ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fault       (fault)
  );

  // ---------------- reference model / scoreboard ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_mem [DEPTH];
  logic [64:0] exp_q[$];        // {fault, pc, data}
  int          due_q[$];        // unstalled-edge count at which it appears
  int          edges;           // edges since reset release
  int          tick;            // unstalled edges since reset release
  logic        cur_valid;
  logic [64:0] cur_resp;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    exp_q.delete();
    due_q.delete();
    edges     = 0;
    tick      = 0;
    cur_valid = 1'b0;
    cur_resp  = {1'b0, 32'd0, NOP};
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_ready"}, ready, 1'b0);
    check_bit({tag, "_valid"}, instr_valid, 1'b0);
    check_bit({tag, "_fault"}, fault, 1'b0);
    check_word({tag, "_instr"}, instr, NOP);
    check_word({tag, "_pc"}, instr_pc, 32'd0);
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs, advances the model across the edge and
  // checks outputs 1 time unit after the edge.
  task automatic cycle(input logic c, input logic [31:0] p, input logic s,
                       input logic le, input logic [AW-1:0] la, input logic [31:0] ld);
    logic        run_ready;
    logic        flt;
    logic [31:0] word;
    ce = c; pc = p; stall = s; load_en = le; load_addr = la; load_data = ld;
    run_ready = (edges >= DEPTH + 1);
    if (!s) tick++;
    if (c && run_ready && !s) begin
      flt  = (p % 4 != 0) || ((p / 4) >= DEPTH);
      word = flt ? NOP : model_mem[(p / 4) % DEPTH];
      exp_q.push_back({flt, p, word});
      due_q.push_back(tick + LAT);
    end
    if (le && edges >= DEPTH) model_mem[la] = ld;   // after the read: read-first
    edges++;
    @(posedge clk);
    #1;
    if (!s) begin
      if (due_q.size() > 0 && due_q[0] == tick) begin
        cur_valid = 1'b1;
        cur_resp  = exp_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        cur_valid = 1'b0;
      end
    end
    check_bit("ready", ready, edges >= DEPTH + 1);
    check_bit("instr_valid", instr_valid, cur_valid);
    if (cur_valid) begin
      check_bit("fault", fault, cur_resp[64]);
      check_word("instr_pc", instr_pc, cur_resp[63:32]);
      check_word("instr", instr, cur_resp[31:0]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] p);
    cycle(1'b1, p, 1'b0, 1'b0, '0, 32'd0);
  endtask

  task automatic drain_and_check(input string tag);
    idle(LAT + 3);
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL %s_drain: observed %0d pending expected 0", tag, exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          ready_low;
    logic [31:0] prog [4];
    logic [31:0] rp;
    int          kind;

    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_006F;

    ce = 1'b0; pc = '0; stall = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    rst = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Fill window with ce held high: no responses until ready, then pc=0 -> NOP
    ready_low = 0;
    for (int i = 0; i < DEPTH + LAT + 4; i++) begin
      fetch(32'd0);
      if (ready === 1'b0) ready_low++;
    end
    vectors++;
    assert (ready_low == DEPTH) else begin
      miscompares++;
      $error("FAIL fill_length: observed %0d expected %0d", ready_low, DEPTH);
    end
    drain_and_check("fill");

    // Load a short program then fetch it back-to-back
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, AW'(i), prog[i]);
    for (int i = 0; i < 4; i++) fetch(32'(i * 4));
    drain_and_check("program");

    // Misaligned and out-of-range fetches
    fetch(32'h0000_0002);
    fetch(32'(DEPTH * 4));
    fetch(32'(DEPTH * 4 + 1));
    fetch(32'hFFFF_FFFC);
    fetch(32'h0000_0004);
    drain_and_check("fault");

    // Stall for 3 cycles in the middle of a stream
    fetch(32'd0);
    fetch(32'd4);
    fetch(32'd8);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'd12, 1'b1, 1'b0, '0, 32'd0);
    fetch(32'd12);
    fetch(32'd0);
    drain_and_check("stall");

    // Same-cycle load and fetch of word 5: old word first, new word next
    cycle(1'b1, 32'd20, 1'b0, 1'b1, AW'(5), 32'hDEAD_BEEF);
    fetch(32'd20);
    drain_and_check("read_first");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)      rp = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (kind < 8) rp = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else               rp = $urandom;
      cycle(1'($urandom_range(0, 3) != 0), rp, 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, DEPTH - 1)), $urandom);
    end
    drain_and_check("random");

    // Reset with two fetches in flight; the loaded word must not survive
    cycle(1'b0, 32'd0, 1'b0, 1'b1, '0, 32'h1234_5678);
    fetch(32'd0);
    fetch(32'd4);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    ce = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(DEPTH + 1);
    fetch(32'd0);
    drain_and_check("refill");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
